muldiv_div_sequencer: RTL and testbench

- Multi-cycle sequencer for RV32M DIV, DIVU, REM and REMU.
- Sits beside the single-cycle arithmetic unit in EX. Decode issues divide ops to it over a valid/ready handshake, and EX stalls until the result handshake completes.
- Computes one quotient bit per cycle with a restoring shift-subtract datapath that it owns and sequences itself.
- Handles the RISC-V divide-by-zero and signed-overflow cases in the preparation cycle, without iterating.

---
 rtl/muldiv_div_sequencer.sv | 137 +++++++++++++
 tb/tb_muldiv_div_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_div_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU): restoring shift-subtract,
// one quotient bit per cycle, with divide-by-zero and signed overflow resolved up front.
module muldiv_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      f3;
  logic [XLEN-1:0] a, b, dvs, quo, rem;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r;

  logic            is_signed, sign1, sign2, div_zero, ovf, fix_neg;
  logic [XLEN-1:0] a_abs, b_abs, fix_sel;
  logic [XLEN:0]   rem_sh, trial;
  logic            unused_f3;

  assign unused_f3 = funct3[2];

  assign is_signed = !f3[0];
  assign sign1     = is_signed && a[XLEN-1];
  assign sign2     = is_signed && b[XLEN-1];
  assign a_abs     = sign1 ? -a : a;
  assign b_abs     = sign2 ? -b : b;
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Trial subtract is one bit wider so divisors >= 2^(XLEN-1) never lose the borrow.
  assign rem_sh    = {rem, quo[XLEN-1]};
  assign trial     = rem_sh - {1'b0, dvs};

  assign fix_sel   = f3[1] ? rem : quo;
  assign fix_neg   = is_signed && (f3[1] ? neg_r : neg_q);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the request
  // side is accepted only when idle and not flushed, the result is held until taken.
  assign in_ready  = (state == S_IDLE) && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid && in_ready) state_nx = S_PREP;
      S_PREP: state_nx = (div_zero || ovf) ? S_DONE : S_CALC;
      S_CALC: if (cnt == '0) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f3     <= '0;
      a      <= '0;
      b      <= '0;
      dvs    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            f3 <= funct3[1:0];
            a  <= op1;
            b  <= op2;
          end
        end
        S_PREP: begin
          neg_q <= sign1 ^ sign2;
          neg_r <= sign1;
          dvs   <= b_abs;
          if (div_zero) begin
            result <= f3[1] ? a : '1;
          end else if (ovf) begin
            // Overflow quotient is the dividend itself (most negative value).
            result <= f3[1] ? '0 : a;
          end else begin
            rem <= '0;
            quo <= a_abs;
            cnt <= CW'(XLEN - 1);
          end
        end
        S_CALC: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        S_FIX: result <= fix_neg ? -fix_sel : fix_sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_div_sequencer.sv
`timescale 1ns/1ps
// Bench for muldiv_div_sequencer: directed corner cases, randomized operations checked
// against an arithmetic reference model, backpressure, flush and mid-operation reset.
module tb_muldiv_div_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]      funct3, dbg_state;
  logic [XLEN-1:0] op1, op2, result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  muldiv_div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op1(op1), .op2(op2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RISC-V divide rules.
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, r;
    sx = x;
    sy = y;
    if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (x == MIN && y == 32'hFFFF_FFFF) return f[1] ? 32'd0 : MIN;
      r = f[1] ? (sx % sy) : (sx / sy);
      return r;
    end
    return f[1] ? (x % y) : (x / y);
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 2;
    if (!f[0] && x == MIN && y == 32'hFFFF_FFFF) return 2;
    return XLEN + 3;
  endfunction

  // Presents a request (cycle T = handshake cycle), then waits for and checks the result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    int guard, cyc, lat;
    logic [31:0] exp;
    exp = ref_div(f, x, y);
    lat = ref_lat(f, x, y);
    exp_q.push_back(exp);
    out_ready = (hold == 0);
    funct3 = f; op1 = x; op2 = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    exp = exp_q.pop_front();
    check({tag, "_res"}, result, exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_res"}, result, exp);
        check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  // Starts an operation and returns at the negedge of the given cycle after the handshake.
  task automatic start_and_wait(input logic [2:0] f, input logic [31:0] x,
                                input logic [31:0] y, input int upto);
    int guard;
    funct3 = f; op1 = x; op2 = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c < upto; c++) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    int          hold;
    bit          seen;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct3 = 3'b100; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);

    // directed corner cases
    run_op("div_neg7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_neg7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_wide",    3'b101, 32'hFFFF_FFFF, MIN, 0);
    run_op("remu_wide",    3'b111, 32'hFFFF_FFFF, MIN, 0);
    run_op("div_by0",      3'b100, 32'h1234, 32'd0, 0);
    run_op("remu_by0",     3'b111, 32'h1234, 32'd0, 0);
    run_op("div_ovf",      3'b100, MIN, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",      3'b110, MIN, 32'hFFFF_FFFF, 0);
    run_op("div_bp",       3'b100, 32'd1000, 32'hFFFF_FFFD, 5);
    run_op("div_by0_bp",   3'b100, 32'h55, 32'd0, 5);

    // flush at CALC cycle 10 (cycle T+12)
    start_and_wait(3'b101, 32'hDEAD_BEEF, 32'd3, 12);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {30'd0, busy, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {31'd0, seen}, 32'd0);

    // flush coincident with a request in IDLE: not accepted
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'b101; op1 = 32'd9; op2 = 32'd2;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_req", {31'd0, busy}, 32'd0);
    run_op("divu_100_7",   3'b101, 32'd100, 32'd7, 0);

    // synchronous reset mid-CALC, held with a pending request
    start_and_wait(3'b100, 32'd12345, 32'd3, 15);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_flags", {30'd0, busy, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    in_valid = 1'b1; funct3 = 3'b101; op1 = 32'd50; op2 = 32'd5;
    repeat (3) @(negedge clk);
    check("rst_hold_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_busy", {31'd0, busy}, 32'd0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      f = 3'b100 | 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = MIN; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = y | MIN;
        4: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_op("rand", f, x, y, hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
